// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the instruction fetch unit: default widths,
// instruction field positions, opcode constants and the FSM state type.
package fetch_unit_pkg;

    localparam int ADDR_W_DEF  = 12;
    localparam int INSTR_W_DEF = 16;

    // Instruction word field positions
    localparam int OPC_HI  = 15;
    localparam int OPC_LO  = 12;
    localparam int FUNC_HI = 7;
    localparam int FUNC_LO = 0;
    localparam int TGT_HI  = 11;
    localparam int TGT_LO  = 0;

    localparam logic [3:0] OP_LOAD  = 4'b0000;
    localparam logic [3:0] OP_STORE = 4'b0001;
    localparam logic [3:0] OP_JUMP  = 4'b0010;
    localparam logic [3:0] OP_ALU   = 4'b1000;

    // S_REQ  : request outstanding
    // S_KILL : request outstanding, its data will be dropped
    // S_HOLD : instruction register full, waiting for decode
    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_KILL = 2'd1,
        S_HOLD = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/fetch_unit_if.sv
// Bundle of the fetch unit's bus signals.
//   imem_*  : instruction-memory request/ack channel
//   jump*   : redirect from decode
//   instr*, opcode, func, pc : instruction handed to decode
// master = fetch unit side, slave = memory/decode side.
interface fetch_unit_if import fetch_unit_pkg::*; #(
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int INSTR_W = INSTR_W_DEF
);
    logic               imem_req;
    logic [ADDR_W-1:0]  imem_addr;
    logic               imem_ack;
    logic [INSTR_W-1:0] imem_rdata;
    logic               jump;
    logic [ADDR_W-1:0]  jump_addr;
    logic               instr_valid;
    logic               instr_ready;
    logic [INSTR_W-1:0] instr;
    logic [3:0]         opcode;
    logic [7:0]         func;
    logic [ADDR_W-1:0]  pc;

    modport master (
        output imem_req, imem_addr,
        input  imem_ack, imem_rdata,
        input  jump, jump_addr,
        output instr_valid,
        input  instr_ready,
        output instr, opcode, func, pc
    );

    modport slave (
        input  imem_req, imem_addr,
        output imem_ack, imem_rdata,
        output jump, jump_addr,
        input  instr_valid,
        output instr_ready,
        input  instr, opcode, func, pc
    );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch unit. Issues one instruction-memory request at a time,
// latches the returned word into an instruction register for decode and
// handles redirects (jumps) from decode, dropping any in-flight data.
// Ports:
//   clk  : clock, rising edge
//   rst  : asynchronous active-low reset
//   bus  : fetch_unit_if.master (imem channel, jump, instruction output)
module fetch_unit import fetch_unit_pkg::*; #(
    parameter int                ADDR_W   = ADDR_W_DEF,
    parameter int                INSTR_W  = INSTR_W_DEF,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic          clk,
    input  logic          rst,
    fetch_unit_if.master  bus
);

    fetch_state_e        state;
    logic                req_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [ADDR_W-1:0]   fetch_pc;   // next sequential PC, or pending jump target in S_KILL
    logic [ADDR_W-1:0]   pc_q;
    logic [INSTR_W-1:0]  instr_q;
    logic                valid_q;
    logic                ack_v;

    // An ack only counts while a request is actually on the bus.
    assign ack_v = bus.imem_ack & req_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= S_REQ;
            req_q    <= 1'b0;
            addr_q   <= RESET_PC;
            fetch_pc <= RESET_PC;
            pc_q     <= '0;
            instr_q  <= '0;
            valid_q  <= 1'b0;
        end else begin
            case (state)
                S_REQ: begin
                    if (!req_q) begin
                        // First cycle out of reset: nothing issued yet, so a
                        // jump simply retargets the request about to go out.
                        req_q <= 1'b1;
                        if (bus.jump) begin
                            addr_q <= bus.jump_addr;
                        end
                    end else if (bus.jump) begin
                        if (ack_v) begin
                            addr_q <= bus.jump_addr;
                        end else begin
                            fetch_pc <= bus.jump_addr;
                            state    <= S_KILL;
                        end
                    end else if (ack_v) begin
                        instr_q  <= bus.imem_rdata;
                        pc_q     <= addr_q;
                        fetch_pc <= addr_q + 1'b1;
                        valid_q  <= 1'b1;
                        req_q    <= 1'b0;
                        state    <= S_HOLD;
                    end
                end
                S_KILL: begin
                    if (ack_v) begin
                        addr_q <= bus.jump ? bus.jump_addr : fetch_pc;
                        state  <= S_REQ;
                    end else if (bus.jump) begin
                        fetch_pc <= bus.jump_addr;  // latest target wins
                    end
                end
                S_HOLD: begin
                    if (bus.jump) begin
                        valid_q <= 1'b0;
                        addr_q  <= bus.jump_addr;
                        req_q   <= 1'b1;
                        state   <= S_REQ;
                    end else if (bus.instr_ready) begin
                        valid_q <= 1'b0;
                        addr_q  <= fetch_pc;
                        req_q   <= 1'b1;
                        state   <= S_REQ;
                    end
                end
                default: begin
                    state <= S_REQ;
                end
            endcase
        end
    end

    assign bus.imem_req    = req_q;
    assign bus.imem_addr   = addr_q;
    assign bus.instr_valid = valid_q;
    assign bus.instr       = instr_q;
    assign bus.pc          = pc_q;
    assign bus.opcode      = instr_q[OPC_HI:OPC_LO];
    assign bus.func        = instr_q[FUNC_HI:FUNC_LO];

endmodule
